sync_fifo_flex: RTL and testbench

Parametrised successor to the team's single-clock sync FIFO. Adds non-power-of-two depth, a selectable first-word-fall-through read mode, programmable almost-full/almost-empty thresholds, simultaneous push/pop at the full and empty boundaries, and sticky overflow/underflow error flags. It is the general-purpose buffer between streaming producers and consumers in one clock domain, for example as peripheral RX/TX queues or command buffers.

---
 rtl/sync_fifo_flex.sv | 157 +++++++++++++++
 tb/tb_sync_fifo_flex.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flex.sv
// ---------------------------------------------------------------------------
// sync_fifo_flex
// Single-clock FIFO with any depth of 2 or more (not limited to powers of
// two). The read mode is selectable: registered read or first-word-fall-through.
// The almost-full and almost-empty thresholds are set by parameters. Sticky
// overflow and underflow flags record misuse.
//
// Ports
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   flush        : synchronous clear of contents and error flags (beats push/pop)
//   push/data_in : write request and write data
//   pop          : read request
//   data_out     : read data (FWFT=0: valid 1 cycle after pop; FWFT=1: head word)
//   full/empty   : level == DEPTH / level == 0
//   almost_full  : level >= AF_THRESH
//   almost_empty : level <= AE_THRESH
//   level        : current occupancy
//   overflow     : sticky, a push was refused because the FIFO was full
//   underflow    : sticky, a pop was attempted while the FIFO was empty
// ---------------------------------------------------------------------------
module sync_fifo_flex #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int FWFT      = 0,
    parameter int AF_THRESH = DEPTH - 1,
    parameter int AE_THRESH = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           data_in,
    output logic                       full,
    output logic                       almost_full,
    input  logic                       pop,
    output logic [WIDTH-1:0]           data_out,
    output logic                       empty,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] AF_LVL   = LW'(AF_THRESH);
    localparam logic [LW-1:0] AE_LVL   = LW'(AE_THRESH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] wr_ptr_reg;
    logic [LW-1:0] level_reg;
    logic          overflow_reg;
    logic          underflow_reg;

    logic pop_acc;
    logic wr_en;
    logic rd_fire;
    logic wr_fire;

    // Explicit compare-and-clear wrap, so the depth does not have to be a
    // power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    // The status flags decode directly from the level register.
    assign full         = (level_reg == LVL_FULL);
    assign empty        = (level_reg == '0);
    assign almost_full  = (level_reg >= AF_LVL);
    assign almost_empty = (level_reg <= AE_LVL);
    assign level        = level_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

    // A pop in the same cycle frees a slot, so a push into a full FIFO
    // still lands. A pop into an empty FIFO is never accepted, even when a
    // push arrives in the same cycle.
    always_comb begin
        pop_acc = pop & ~empty;
        wr_en   = push & (~full | pop_acc);
        rd_fire = pop_acc & ~flush;
        wr_fire = wr_en & ~flush;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg    <= '0;
            wr_ptr_reg    <= '0;
            level_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else if (flush) begin
            rd_ptr_reg    <= '0;
            wr_ptr_reg    <= '0;
            level_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (rd_fire) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            if (wr_fire && !rd_fire) begin
                level_reg <= level_reg + LW'(1);
            end else if (rd_fire && !wr_fire) begin
                level_reg <= level_reg - LW'(1);
            end
            if (push && !wr_en) begin
                overflow_reg <= 1'b1;
            end
            if (pop && empty) begin
                underflow_reg <= 1'b1;
            end
        end
    end

    // Storage has no reset. The empty flag hides any stale contents.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr_reg] <= data_in;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // The head word is visible without a read request. The output is
            // forced to zero while empty so stale storage never leaks out.
            assign data_out = empty ? '0 : mem[rd_ptr_reg];
        end else begin : g_registered
            logic [WIDTH-1:0] dout_reg;

            // When the FIFO is full, a simultaneous push writes the same
            // slot being read. The read returns the old word, which is the
            // correct FIFO order.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dout_reg <= '0;
                end else if (flush) begin
                    dout_reg <= '0;
                end else if (rd_fire) begin
                    dout_reg <= mem[rd_ptr_reg];
                end
            end

            assign data_out = dout_reg;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_flex.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_flex
// Drives a registered-read instance and a first-word-fall-through instance
// (both DEPTH=5, AF=4, AE=1) with identical stimulus. Both are compared
// against a queue-based reference model after every clock edge.
// ---------------------------------------------------------------------------
module tb_sync_fifo_flex;

    localparam int W     = 8;
    localparam int DEPTH = 5;
    localparam int AF    = 4;
    localparam int AE    = 1;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          push;
    logic          pop;
    logic [W-1:0]  data_in;

    logic          full0, afull0, empty0, aempty0, ovf0, unf0;
    logic [W-1:0]  dout0;
    logic [LW-1:0] level0;
    logic          full1, afull1, empty1, aempty1, ovf1, unf1;
    logic [W-1:0]  dout1;
    logic [LW-1:0] level1;

    sync_fifo_flex #(.WIDTH(W), .DEPTH(DEPTH), .FWFT(0), .AF_THRESH(AF), .AE_THRESH(AE)) u_reg (
        .clk(clk), .rst_n(rst_n), .flush(flush), .push(push), .data_in(data_in),
        .full(full0), .almost_full(afull0), .pop(pop), .data_out(dout0),
        .empty(empty0), .almost_empty(aempty0), .level(level0),
        .overflow(ovf0), .underflow(unf0)
    );

    sync_fifo_flex #(.WIDTH(W), .DEPTH(DEPTH), .FWFT(1), .AF_THRESH(AF), .AE_THRESH(AE)) u_fwft (
        .clk(clk), .rst_n(rst_n), .flush(flush), .push(push), .data_in(data_in),
        .full(full1), .almost_full(afull1), .pop(pop), .data_out(dout1),
        .empty(empty1), .almost_empty(aempty1), .level(level1),
        .overflow(ovf1), .underflow(unf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the queue holds the stored words in order.
    logic [W-1:0] m_q[$];
    logic         m_ovf;
    logic         m_unf;
    logic [W-1:0] m_dout;

    int checks;
    int errors;
    int txn;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s txn=%0d observed=0x%0h expected=0x%0h", tag, txn, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        logic [W-1:0] head;
        n    = m_q.size();
        head = (n > 0) ? m_q[0] : 8'h00;
        chk({tag, "/level"},        32'(level0),  32'(n));
        chk({tag, "/empty"},        32'(empty0),  32'(n == 0));
        chk({tag, "/full"},         32'(full0),   32'(n == DEPTH));
        chk({tag, "/almost_full"},  32'(afull0),  32'(n >= AF));
        chk({tag, "/almost_empty"}, 32'(aempty0), 32'(n <= AE));
        chk({tag, "/overflow"},     32'(ovf0),    32'(m_ovf));
        chk({tag, "/underflow"},    32'(unf0),    32'(m_unf));
        chk({tag, "/dout_reg"},     32'(dout0),   32'(m_dout));
        chk({tag, "/fwft_level"},   32'(level1),  32'(n));
        chk({tag, "/fwft_empty"},   32'(empty1),  32'(n == 0));
        chk({tag, "/fwft_ovf"},     32'(ovf1),    32'(m_ovf));
        chk({tag, "/fwft_unf"},     32'(unf1),    32'(m_unf));
        chk({tag, "/fwft_dout"},    32'(dout1),   32'(head));
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_dout = '0;
    endtask

    // FIFO rules expressed on the queue. The pop is taken first, so a full
    // FIFO with push and pop together has room for the new word.
    task automatic model_update(input bit p, input bit r, input bit f, input logic [W-1:0] d);
        bit pa;
        bit wa;
        if (f) begin
            model_reset();
        end else begin
            pa = r && (m_q.size() > 0);
            wa = p && ((m_q.size() < DEPTH) || pa);
            if (r && m_q.size() == 0) m_unf = 1'b1;
            if (p && !wa)             m_ovf = 1'b1;
            if (pa) m_dout = m_q.pop_front();
            if (wa) m_q.push_back(d);
        end
    endtask

    task automatic step(input string tag, input bit p, input bit r, input bit f, input logic [W-1:0] d);
        push    = p;
        pop     = r;
        flush   = f;
        data_in = d;
        @(posedge clk);
        model_update(p, r, f, d);
        #1;
        txn++;
        $display("txn %0d %s push=%0b pop=%0b flush=%0b din=%02h level=%0d dout=%02h fwft_dout=%02h ovf=%0b unf=%0b",
                 txn, tag, p, r, f, d, level0, dout0, dout1, ovf0, unf0);
        check_all(tag);
        push  = 1'b0;
        pop   = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        txn     = 0;
        rst_n   = 1'b0;
        flush   = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        data_in = '0;
        model_reset();

        // Reset values, checked before any clock edge.
        #3;
        check_all("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Fill to full: level steps 1..5 and the flags track it.
        for (int i = 0; i < DEPTH; i++) step("fill", 1, 0, 0, 8'(8'h10 + i));

        // Push into a full FIFO is dropped and sets overflow.
        step("ovf_push", 1, 0, 0, 8'hAA);

        // Drain, then an extra pop on empty sets underflow.
        for (int i = 0; i < DEPTH; i++) step("drain", 0, 1, 0, 8'h00);
        step("pop_empty", 0, 1, 0, 8'h00);

        // Wrap-around of both pointers past index DEPTH-1.
        for (int i = 0; i < 3; i++) step("wrap_pre_push", 1, 0, 0, 8'(8'h01 + i));
        for (int i = 0; i < 3; i++) step("wrap_pre_pop", 0, 1, 0, 8'h00);
        for (int i = 0; i < DEPTH; i++) step("wrap_push", 1, 0, 0, 8'(8'h20 + i));
        for (int i = 0; i < DEPTH; i++) step("wrap_drain", 0, 1, 0, 8'h00);

        // Push and pop together at the full and empty boundaries.
        step("flush1", 0, 0, 1, 8'h00);
        for (int i = 0; i < DEPTH; i++) step("sim_fill", 1, 0, 0, 8'(8'h31 + i));
        step("sim_full", 1, 1, 0, 8'h30);
        for (int i = 0; i < DEPTH; i++) step("sim_drain", 0, 1, 0, 8'h00);
        step("sim_empty", 1, 1, 0, 8'h40);
        step("sim_pop40", 0, 1, 0, 8'h00);

        // First-word-fall-through behaviour.
        step("flush2", 0, 0, 1, 8'h00);
        step("fwft_push55", 1, 0, 0, 8'h55);
        step("fwft_push66", 1, 0, 0, 8'h66);
        step("fwft_pop1", 0, 1, 0, 8'h00);
        step("fwft_pop2", 0, 1, 0, 8'h00);

        // Flush with level 3 and overflow set, alongside a push.
        for (int i = 0; i < DEPTH; i++) step("fl_fill", 1, 0, 0, 8'($urandom));
        step("fl_ovf", 1, 0, 0, 8'h99);
        step("fl_pop", 0, 1, 0, 8'h00);
        step("fl_pop", 0, 1, 0, 8'h00);
        step("flush_push", 1, 0, 1, 8'h77);

        // Randomised traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            step("rand", ($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 50),
                 ($urandom_range(0, 63) == 0), 8'($urandom));
        end

        // Asynchronous reset in the middle of a burst, with no clock edge.
        for (int i = 0; i < 3; i++) step("burst", 1, 0, 0, 8'(8'hC0 + i));
        push    = 1'b1;
        data_in = 8'hEE;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_reset");
        push = 1'b0;
        #2 rst_n = 1'b1;
        step("post_reset_push", 1, 0, 0, 8'h5A);
        step("post_reset_pop", 0, 1, 0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
